// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that multiplexes NUM_PORTS memory clients onto one shared memory port,
// with one transaction in flight, registered request capture and a hung-transaction watchdog.
module mem_port_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int MASK_WIDTH     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             req_read,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_PORTS*MASK_WIDTH-1:0]  req_byte_enable,
  output logic [NUM_PORTS-1:0]             req_resp,
  output logic [NUM_PORTS-1:0]             req_err,
  output logic [DATA_WIDTH-1:0]            req_rdata,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  output logic [MASK_WIDTH-1:0]            mem_byte_enable,
  input  logic                             mem_resp,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic                             timeout_flag
);

  localparam int              GW          = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int              CW          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit              WDOG_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0]   TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0]   LAST_PORT   = GW'(NUM_PORTS - 1);
  localparam logic [GW:0]     NP_EXT      = (GW+1)'(NUM_PORTS);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          grant_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [MASK_WIDTH-1:0]  be_q;
  logic                   op_write_q;
  logic [CW-1:0]          count_q, count_d;
  logic                   timeout_flag_q;

  logic [ADDR_WIDTH-1:0]  port_addr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0]  port_wdata [NUM_PORTS];
  logic [MASK_WIDTH-1:0]  port_be    [NUM_PORTS];
  logic [NUM_PORTS-1:0]   pending;
  logic                   any_pending;
  logic                   capture;
  logic                   timeout_hit;
  logic [GW-1:0]          sel_port;
  logic [GW:0]            rr_sum;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign port_addr[gi]  = req_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign port_wdata[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign port_be[gi]    = req_byte_enable[gi*MASK_WIDTH +: MASK_WIDTH];
    assign pending[gi]    = req_read[gi] | req_write[gi];
  end

  assign any_pending = |pending;
  assign capture     = (state_q == ST_IDLE) && any_pending;
  assign timeout_hit = WDOG_EN && (count_q == TIMEOUT_VAL);

  // Scan from the farthest offset down so the nearest pending port after grant_q wins.
  always_comb begin
    sel_port = grant_q;
    rr_sum   = '0;
    for (int off = NUM_PORTS; off >= 1; off--) begin
      rr_sum = {1'b0, grant_q} + (GW+1)'(off);
      if (rr_sum >= NP_EXT) begin
        rr_sum = rr_sum - NP_EXT;
      end
      if (pending[rr_sum[GW-1:0]]) begin
        sel_port = rr_sum[GW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_pending) state_d = ST_BUSY;
      ST_BUSY: if (mem_resp || timeout_hit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A response in the timeout cycle wins, so the error pulse is gated by !mem_resp.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    req_resp  = '0;
    req_err   = '0;
    if (state_q == ST_BUSY) begin
      mem_read  = ~op_write_q;
      mem_write = op_write_q;
      if (mem_resp) begin
        req_resp[grant_q] = 1'b1;
      end else if (timeout_hit) begin
        req_err[grant_q] = 1'b1;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (capture) begin
      count_d = '0;
    end else if (state_q == ST_BUSY && !mem_resp && !timeout_hit && WDOG_EN) begin
      count_d = count_q + CW'(1);
    end
  end

  // grant_q doubles as last_grant: it only changes on capture, so it names the in-flight port.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q        <= LAST_PORT;
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      op_write_q     <= 1'b0;
      count_q        <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (capture) begin
        grant_q    <= sel_port;
        addr_q     <= port_addr[sel_port];
        wdata_q    <= port_wdata[sel_port];
        be_q       <= port_be[sel_port];
        op_write_q <= req_write[sel_port];
      end
      if (state_q == ST_BUSY && !mem_resp && timeout_hit) begin
        timeout_flag_q <= 1'b1;
      end
    end
  end

  assign mem_address     = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_byte_enable = be_q;
  assign req_rdata       = mem_rdata;
  assign timeout_flag    = timeout_flag_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: requesters and memory are driven from tasks and
// expected transactions go through a scoreboard queue popped when the DUT completes them.
module tb_mem_port_arbiter;

  localparam int NP = 2;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MW = 2;
  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     req_read;
  logic [NP-1:0]     req_write;
  logic [NP*AW-1:0]  req_address;
  logic [NP*DW-1:0]  req_wdata;
  logic [NP*MW-1:0]  req_byte_enable;
  logic [NP-1:0]     req_resp;
  logic [NP-1:0]     req_err;
  logic [DW-1:0]     req_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [AW-1:0]     mem_address;
  logic [DW-1:0]     mem_wdata;
  logic [MW-1:0]     mem_byte_enable;
  logic              mem_resp;
  logic [DW-1:0]     mem_rdata;
  logic              timeout_flag;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          port;
    logic        wr;
    logic        err;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] rdata;
  } txn_t;

  txn_t sb[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_read(req_read), .req_write(req_write), .req_address(req_address),
    .req_wdata(req_wdata), .req_byte_enable(req_byte_enable),
    .req_resp(req_resp), .req_err(req_err), .req_rdata(req_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .timeout_flag(timeout_flag)
  );

  // At most one completion/abort pulse may be visible in any cycle.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if ($countones({req_resp, req_err}) > 1) begin
        failures++;
        $display("FAIL onehot_pulse: resp=%b err=%b required at most one bit set", req_resp, req_err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within its time budget");
    $fatal(1, "time budget exceeded");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int p, input logic rd, input logic wr, input logic [15:0] a,
                           input logic [15:0] d, input logic [1:0] be);
    req_read[p]                = rd;
    req_write[p]               = wr;
    req_address[p*AW +: AW]    = a;
    req_wdata[p*DW +: DW]      = d;
    req_byte_enable[p*MW +: MW] = be;
  endtask

  task automatic clear_reqs();
    req_read  = '0;
    req_write = '0;
  endtask

  task automatic push_exp(input int p, input logic wr, input logic err, input logic [15:0] a,
                          input logic [15:0] d, input logic [1:0] be, input logic [15:0] rd);
    txn_t t;
    t.port = p; t.wr = wr; t.err = err; t.addr = a; t.wdata = d; t.be = be; t.rdata = rd;
    sb.push_back(t);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_reqs();
    step();
    step();
    checks++;
    if ({mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, req_resp, req_err, timeout_flag} !== '0) begin
      failures++;
      $display("FAIL reset_state: rd=%b wr=%b addr=%h wdata=%h be=%b resp=%b err=%b tflag=%b required all zero",
               mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, req_resp, req_err, timeout_flag);
    end
    reset = 1'b0;
    mem_resp = 1'b1;
    mem_rdata = 16'h7777;
    #1;
    checks++;
    if (req_resp !== 2'b00) begin
      failures++;
      $display("FAIL idle_resp_ignored: resp=%b required 00", req_resp);
    end
    checks++;
    if (req_rdata !== 16'h7777) begin
      failures++;
      $display("FAIL rdata_passthrough: got %h required 7777", req_rdata);
    end
    step();
    checks++;
    if ({mem_read, mem_write} !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_stray_resp: rd=%b wr=%b required 00", mem_read, mem_write);
    end
    mem_resp = 1'b0;
  endtask

  task automatic test_single_read();
    txn_t e;
    push_exp(0, 1'b0, 1'b0, 16'h1234, 16'h0000, 2'b00, 16'hBEEF);
    drive_req(0, 1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00);
    #1;
    checks++;
    if (mem_read !== 1'b0) begin
      failures++;
      $display("FAIL read_cycle0: mem_read=%b required 0", mem_read);
    end
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 3) begin
        mem_resp = 1'b1;
        mem_rdata = 16'hBEEF;
      end
      #1;
      checks++;
      if ({mem_read, mem_write, mem_address} !== {2'b10, 16'h1234}) begin
        failures++;
        $display("FAIL read_busy_c%0d: rd=%b wr=%b addr=%h required rd=1 wr=0 addr=1234",
                 c, mem_read, mem_write, mem_address);
      end
      if (c < 3) begin
        checks++;
        if (req_resp !== 2'b00) begin
          failures++;
          $display("FAIL read_early_resp_c%0d: resp=%b required 00", c, req_resp);
        end
      end else begin
        e = sb.pop_front();
        checks++;
        if (req_resp !== 2'(1 << e.port) || req_err !== 2'b00) begin
          failures++;
          $display("FAIL read_resp: resp=%b err=%b required resp=%b err=00", req_resp, req_err, 2'(1 << e.port));
        end
        checks++;
        if (req_rdata !== e.rdata) begin
          failures++;
          $display("FAIL read_rdata: got %h required %h", req_rdata, e.rdata);
        end
      end
    end
    step();
    clear_reqs();
    mem_resp = 1'b0;
    #1;
    checks++;
    if ({mem_read, mem_write, req_resp} !== 4'b0000) begin
      failures++;
      $display("FAIL read_back_to_idle: rd=%b wr=%b resp=%b required all zero", mem_read, mem_write, req_resp);
    end
  endtask

  task automatic test_round_robin();
    txn_t e;
    int last_m;
    int p;
    reset = 1'b1;
    clear_reqs();
    step();
    reset = 1'b0;
    last_m = NP - 1;
    drive_req(0, 1'b1, 1'b0, 16'h0100, 16'h0000, 2'b00);
    drive_req(1, 1'b1, 1'b0, 16'h0200, 16'h0000, 2'b00);
    for (int t = 0; t < 6; t++) begin
      p = (last_m + 1) % NP;
      last_m = p;
      push_exp(p, 1'b0, 1'b0, (p == 0) ? 16'h0100 : 16'h0200, 16'h0000, 2'b00, 16'hC000 + 16'(t));
      step();
      mem_resp = 1'b1;
      mem_rdata = 16'hC000 + 16'(t);
      #1;
      e = sb.pop_front();
      checks++;
      if (req_resp !== 2'(1 << e.port)) begin
        failures++;
        $display("FAIL rr_grant_t%0d: resp=%b required %b", t, req_resp, 2'(1 << e.port));
      end
      checks++;
      if (mem_address !== e.addr || req_rdata !== e.rdata) begin
        failures++;
        $display("FAIL rr_data_t%0d: addr=%h rdata=%h required addr=%h rdata=%h",
                 t, mem_address, req_rdata, e.addr, e.rdata);
      end
      step();
      mem_resp = 1'b0;
      #1;
      checks++;
      if ({mem_read, req_resp} !== 3'b000) begin
        failures++;
        $display("FAIL rr_idle_t%0d: rd=%b resp=%b required all zero", t, mem_read, req_resp);
      end
    end
    clear_reqs();
  endtask

  task automatic test_write_stable();
    txn_t e;
    push_exp(1, 1'b1, 1'b0, 16'h0040, 16'hA5A5, 2'b01, 16'h0000);
    drive_req(1, 1'b1, 1'b1, 16'h0040, 16'hA5A5, 2'b01);
    e = sb.pop_front();
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 3) mem_resp = 1'b1;
      #1;
      checks++;
      if ({mem_read, mem_write} !== {~e.wr, e.wr} || mem_address !== e.addr ||
          mem_wdata !== e.wdata || mem_byte_enable !== e.be) begin
        failures++;
        $display("FAIL write_stable_c%0d: rd=%b wr=%b addr=%h wdata=%h be=%b required rd=0 wr=1 addr=%h wdata=%h be=%b",
                 c, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, e.addr, e.wdata, e.be);
      end
      if (c == 1) drive_req(1, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 2'b11);
    end
    checks++;
    if (req_resp !== 2'(1 << e.port)) begin
      failures++;
      $display("FAIL write_resp: resp=%b required %b", req_resp, 2'(1 << e.port));
    end
    step();
    clear_reqs();
    mem_resp = 1'b0;
  endtask

  task automatic test_timeout();
    txn_t e;
    push_exp(0, 1'b0, 1'b1, 16'h0ABC, 16'h0000, 2'b00, 16'h0000);
    drive_req(0, 1'b1, 1'b0, 16'h0ABC, 16'h0000, 2'b00);
    for (int c = 1; c <= 5; c++) begin
      step();
      #1;
      if (c < 5) begin
        checks++;
        if ({req_err, req_resp, mem_read} !== 5'b00001) begin
          failures++;
          $display("FAIL timeout_wait_c%0d: err=%b resp=%b rd=%b required err=00 resp=00 rd=1",
                   c, req_err, req_resp, mem_read);
        end
      end else begin
        e = sb.pop_front();
        checks++;
        if (req_err !== 2'(1 << e.port) || req_resp !== 2'b00) begin
          failures++;
          $display("FAIL timeout_err: err=%b resp=%b required err=%b resp=00", req_err, req_resp, 2'(1 << e.port));
        end
      end
    end
    step();
    clear_reqs();
    #1;
    checks++;
    if ({mem_read, mem_write, req_err} !== 4'b0000) begin
      failures++;
      $display("FAIL timeout_drop: rd=%b wr=%b err=%b required all zero", mem_read, mem_write, req_err);
    end
    checks++;
    if (timeout_flag !== 1'b1) begin
      failures++;
      $display("FAIL timeout_flag_set: got %b required 1", timeout_flag);
    end
    push_exp(1, 1'b0, 1'b0, 16'h0123, 16'h0000, 2'b00, 16'h4321);
    drive_req(1, 1'b1, 1'b0, 16'h0123, 16'h0000, 2'b00);
    step();
    mem_resp = 1'b1;
    mem_rdata = 16'h4321;
    #1;
    e = sb.pop_front();
    checks++;
    if (req_resp !== 2'(1 << e.port) || req_rdata !== e.rdata || mem_address !== e.addr) begin
      failures++;
      $display("FAIL after_timeout_service: resp=%b rdata=%h addr=%h required resp=%b rdata=%h addr=%h",
               req_resp, req_rdata, mem_address, 2'(1 << e.port), e.rdata, e.addr);
    end
    step();
    clear_reqs();
    mem_resp = 1'b0;
    step();
    checks++;
    if (timeout_flag !== 1'b1) begin
      failures++;
      $display("FAIL timeout_flag_sticky: got %b required 1", timeout_flag);
    end
  endtask

  task automatic test_resp_on_timeout();
    txn_t e;
    reset = 1'b1;
    clear_reqs();
    step();
    step();
    reset = 1'b0;
    checks++;
    if (timeout_flag !== 1'b0) begin
      failures++;
      $display("FAIL timeout_flag_reset: got %b required 0", timeout_flag);
    end
    push_exp(1, 1'b0, 1'b0, 16'h0777, 16'h0000, 2'b00, 16'h1357);
    drive_req(1, 1'b1, 1'b0, 16'h0777, 16'h0000, 2'b00);
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 5) begin
        mem_resp = 1'b1;
        mem_rdata = 16'h1357;
      end
      #1;
      if (c < 5) begin
        checks++;
        if ({req_resp, req_err} !== 4'b0000) begin
          failures++;
          $display("FAIL race_wait_c%0d: resp=%b err=%b required 00 00", c, req_resp, req_err);
        end
      end else begin
        e = sb.pop_front();
        checks++;
        if (req_resp !== 2'(1 << e.port) || req_err !== 2'b00 || req_rdata !== e.rdata) begin
          failures++;
          $display("FAIL race_resp_wins: resp=%b err=%b rdata=%h required resp=%b err=00 rdata=%h",
                   req_resp, req_err, req_rdata, 2'(1 << e.port), e.rdata);
        end
      end
    end
    step();
    clear_reqs();
    mem_resp = 1'b0;
    #1;
    checks++;
    if ({timeout_flag, mem_read} !== 2'b00) begin
      failures++;
      $display("FAIL race_no_flag: tflag=%b rd=%b required 0 0", timeout_flag, mem_read);
    end
  endtask

  task automatic test_reset_mid_busy();
    txn_t e;
    drive_req(0, 1'b1, 1'b0, 16'h0ABC, 16'h0000, 2'b00);
    step();
    drive_req(1, 1'b1, 1'b0, 16'h0BBB, 16'h0000, 2'b00);
    step();
    reset = 1'b1;
    step();
    checks++;
    if ({mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, req_resp, req_err, timeout_flag} !== '0) begin
      failures++;
      $display("FAIL midbusy_reset: rd=%b wr=%b addr=%h wdata=%h be=%b resp=%b err=%b tflag=%b required all zero",
               mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, req_resp, req_err, timeout_flag);
    end
    reset = 1'b0;
    push_exp(0, 1'b0, 1'b0, 16'h0ABC, 16'h0000, 2'b00, 16'h2468);
    step();
    mem_resp = 1'b1;
    mem_rdata = 16'h2468;
    #1;
    e = sb.pop_front();
    checks++;
    if (req_resp !== 2'(1 << e.port) || mem_address !== e.addr || mem_read !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_grant: resp=%b addr=%h rd=%b required resp=%b addr=%h rd=1",
               req_resp, mem_address, mem_read, 2'(1 << e.port), e.addr);
    end
    step();
    clear_reqs();
    mem_resp = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    req_read        = '0;
    req_write       = '0;
    req_address     = '0;
    req_wdata       = '0;
    req_byte_enable = '0;
    mem_resp        = 1'b0;
    mem_rdata       = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_stable();
    test_timeout();
    test_resp_on_timeout();
    test_reset_mid_busy();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
